dsram_resp: RTL and testbench

- Responder side of the data-SRAM request interface driven by the memory-access pipeline stage (en/wen/sel/addr/wdata).
- Holds a word-organised, byte-writable data RAM and returns read data after a configurable latency.
- Raises stallreq while busy so the pipeline can freeze.
- Used as the on-chip data memory in simulation and FPGA builds. It sits between the memory-access stage and the data-collect stage.

---
 rtl/dsram_resp_pkg.sv | 18 +
 rtl/dsram_array.sv | 38 +++
 rtl/dsram_resp.sv | 140 ++++++++++++++
 tb/tb_dsram_resp.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dsram_resp_pkg.sv
// Shared defines for the data-SRAM responder: default geometry, latency and FSM encoding.
// Pure declarations, no logic.
// Imported by dsram_resp and its bench.
package dsram_resp_pkg;

  // Default word-address width: 2^12 words of 32 bits
  localparam int DSRAM_ADDR_W  = 12;
  // Default request-to-response latency in cycles (legal 1..15)
  localparam int DSRAM_LATENCY = 1;
  // Latency counter width; maximum load is 14 so it never wraps
  localparam int DSRAM_CNT_W   = 4;

  typedef enum logic {
    DSRAM_IDLE = 1'b0,
    DSRAM_WAIT = 1'b1
  } dsram_state_t;

endpackage

// File: rtl/dsram_array.sv
// Word-organised data RAM with per-byte write enables and a registered read port.
// Latency: write commits at the edge; read data valid the cycle after i_re.
// Read register only changes on i_re, so o_rdata holds between reads. No reset.
module dsram_array #(
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];
  logic [31:0] r_rdata;

  // Byte-lane write: only lanes with i_be set are updated
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we && i_be[i]) begin
        r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // Registered read, enabled so the last word read stays on the output
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dsram_resp.sv
// Data-SRAM responder: accepts en/wen/sel/addr/wdata requests and answers reads from on-chip RAM.
// Latency: response in cycle T+LATENCY after the accept cycle T (LATENCY 1..15).
// Backpressure: stallreq is high while a response is pending (LATENCY>1); requests seen then are dropped.
module dsram_resp
  import dsram_resp_pkg::*;
#(
  parameter int          ADDR_W    = DSRAM_ADDR_W,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = DSRAM_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic        data_sram_wen,
  input  logic [3:0]  data_sram_sel,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        rdata_valid,
  output logic        stallreq,
  output logic        addr_err
);

  localparam logic [DSRAM_CNT_W-1:0] CNT_LOAD = DSRAM_CNT_W'(LATENCY - 1);

  dsram_state_t            r_state, w_state_nxt;
  logic [DSRAM_CNT_W-1:0]  r_cnt, w_cnt_nxt;

  logic                    r_pend_rd;
  logic                    r_pend_err;
  logic [ADDR_W-1:0]       r_pend_idx;

  logic                    r_rdata_valid;
  logic                    r_addr_err;
  logic                    r_show;

  logic                    w_in_range;
  logic [ADDR_W-1:0]       w_idx;
  logic                    w_accept;
  logic                    w_fire;
  logic                    w_fire_rd;
  logic                    w_fire_err;
  logic [ADDR_W-1:0]       w_fire_idx;
  logic [31:0]             w_ram_rdata;
  logic                    w_unused;

  assign w_in_range = (data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign w_idx      = data_sram_addr[ADDR_W+1:2];
  assign w_unused   = &{1'b0, data_sram_addr[1:0]};

  // Requests are only taken in IDLE; during reset nothing is accepted
  assign w_accept = data_sram_en && (r_state == DSRAM_IDLE) && !rst;

  // Response edge: the accept edge itself for LATENCY=1, else the last WAIT edge.
  // The RAM read is deferred to this edge: no request can be accepted in WAIT, so
  // the word cannot change between acceptance and here.
  assign w_fire     = (LATENCY == 1) ? w_accept
                                     : ((r_state == DSRAM_WAIT) && (r_cnt == 4'd1) && !rst);
  assign w_fire_rd  = (LATENCY == 1) ? !data_sram_wen : r_pend_rd;
  assign w_fire_err = (LATENCY == 1) ? !w_in_range    : r_pend_err;
  assign w_fire_idx = (LATENCY == 1) ? w_idx          : r_pend_idx;

  // FSM state and latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DSRAM_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: IDLE->WAIT on accept when LATENCY>1, back to IDLE as the count expires
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      DSRAM_IDLE: begin
        if (w_accept && (LATENCY > 1)) begin
          w_state_nxt = DSRAM_WAIT;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      DSRAM_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = DSRAM_IDLE;
        end
      end
      default: begin
        w_state_nxt = DSRAM_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Capture what the pending response needs at the accept edge
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pend_rd  <= !data_sram_wen;
      r_pend_err <= !w_in_range;
      r_pend_idx <= w_idx;
    end
  end

  // Response pulses and the rdata source select (RAM word or zero for out-of-range)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata_valid <= 1'b0;
      r_addr_err    <= 1'b0;
      r_show        <= 1'b0;
    end else begin
      r_rdata_valid <= w_fire && w_fire_rd;
      r_addr_err    <= w_fire && w_fire_err;
      if (w_fire && w_fire_rd) begin
        r_show <= !w_fire_err;
      end
    end
  end

  dsram_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .i_clk   (clk),
    .i_we    (w_accept && data_sram_wen && w_in_range),
    .i_be    (data_sram_sel),
    .i_waddr (w_idx),
    .i_wdata (data_sram_wdata),
    .i_re    (w_fire && w_fire_rd && !w_fire_err),
    .i_raddr (w_fire_idx),
    .o_rdata (w_ram_rdata)
  );

  assign data_sram_rdata = r_show ? w_ram_rdata : 32'h0;
  assign rdata_valid     = r_rdata_valid;
  assign addr_err        = r_addr_err;
  assign stallreq        = (r_state == DSRAM_WAIT);

endmodule

// File: tb/tb_dsram_resp.sv
// Bench for dsram_resp: one instance at LATENCY=1 driven from a vector table,
// one at LATENCY=3 driven by hand-written multi-cycle sequences.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_dsram_resp;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // LATENCY=1 instance signals
  logic        rst1, en1, wen1;
  logic [3:0]  sel1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        vld1, stall1, err1;

  // LATENCY=3 instance signals
  logic        rst3, en3, wen3;
  logic [3:0]  sel3;
  logic [31:0] addr3, wdata3, rdata3;
  logic        vld3, stall3, err3;

  dsram_resp #(.ADDR_W(12), .BASE_ADDR(32'h0), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst1), .data_sram_en(en1), .data_sram_wen(wen1),
    .data_sram_sel(sel1), .data_sram_addr(addr1), .data_sram_wdata(wdata1),
    .data_sram_rdata(rdata1), .rdata_valid(vld1), .stallreq(stall1), .addr_err(err1)
  );

  dsram_resp #(.ADDR_W(12), .BASE_ADDR(32'h0), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst3), .data_sram_en(en3), .data_sram_wen(wen3),
    .data_sram_sel(sel3), .data_sram_addr(addr3), .data_sram_wdata(wdata3),
    .data_sram_rdata(rdata3), .rdata_valid(vld3), .stallreq(stall3), .addr_err(err3)
  );

  typedef struct {
    logic        en;
    logic        wen;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_vld;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step1(input logic en, input logic wen, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    en1 = en; wen1 = wen; sel1 = sel; addr1 = addr; wdata1 = wdata;
    @(negedge clk);
  endtask

  task automatic step3(input logic en, input logic wen, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    en3 = en; wen3 = wen; sel3 = sel; addr3 = addr; wdata3 = wdata;
    @(negedge clk);
  endtask

  task automatic idle3();
    step3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    // Vector table for LATENCY=1: expectations are the response to the previous row
    //          en    wen   sel   addr          wdata         vld   err   rdata
    vt[0]  = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0,        1'b0, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0,        1'b0, 1'b0, 32'h0};
    vt[4]  = '{1'b1, 1'b1, 4'h2, 32'h0000_0010, 32'h0000_AA00, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vt[5]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0013, 32'h0,        1'b0, 1'b0, 32'hDEAD_BEEF};
    vt[6]  = '{1'b1, 1'b1, 4'hF, 32'h0001_0000, 32'h1234_5678, 1'b1, 1'b0, 32'hDEAD_AAEF};
    vt[7]  = '{1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0,        1'b0, 1'b1, 32'hDEAD_AAEF};
    vt[8]  = '{1'b1, 1'b0, 4'hF, 32'h0000_0000, 32'h0,        1'b1, 1'b1, 32'h0};
    vt[9]  = '{1'b1, 1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hCAFE_F00D};
    vt[10] = '{1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0,        1'b0, 1'b0, 32'hCAFE_F00D};
    vt[11] = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0,        1'b1, 1'b0, 32'hDEAD_AAEF};
    vt[12] = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0,        1'b0, 1'b0, 32'hDEAD_AAEF};

    rst1 = 1'b1; en1 = 1'b0; wen1 = 1'b0; sel1 = 4'h0; addr1 = 32'h0; wdata1 = 32'h0;
    rst3 = 1'b1; en3 = 1'b0; wen3 = 1'b0; sel3 = 4'h0; addr3 = 32'h0; wdata3 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b0;
    rst3 = 1'b0;

    // ---- LATENCY=1 table: write/read, byte lane, out-of-range, sel=0 ----
    for (int i = 0; i < 13; i++) begin
      step1(vt[i].en, vt[i].wen, vt[i].sel, vt[i].addr, vt[i].wdata);
      chk($sformatf("l1_vld[%0d]", i),   {31'h0, vld1},   {31'h0, vt[i].e_vld});
      chk($sformatf("l1_err[%0d]", i),   {31'h0, err1},   {31'h0, vt[i].e_err});
      chk($sformatf("l1_rdata[%0d]", i), rdata1,          vt[i].e_rdata);
      chk($sformatf("l1_stall[%0d]", i), {31'h0, stall1}, 32'h0);
    end

    // ---- LATENCY=1 streaming: 8 writes then 8 back-to-back reads ----
    for (int c = 0; c < 18; c++) begin
      if (c < 8)
        step1(1'b1, 1'b1, 4'hF, 32'(c * 4), 32'(32'h100 + c));
      else if (c < 16)
        step1(1'b1, 1'b0, 4'hF, 32'((c - 8) * 4), 32'h0);
      else
        step1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      chk($sformatf("stream_vld[%0d]", c), {31'h0, vld1},
          {31'h0, ((c >= 9) && (c <= 16)) ? 1'b1 : 1'b0});
      chk($sformatf("stream_stall[%0d]", c), {31'h0, stall1}, 32'h0);
      if ((c >= 9) && (c <= 16))
        chk($sformatf("stream_rdata[%0d]", c), rdata1, 32'(32'h100 + (c - 9)));
    end

    // ---- LATENCY=3: reset state ----
    chk("l3_reset_rdata", rdata3, 32'h0);
    chk("l3_reset_flags", {29'h0, vld3, err3, stall3}, 32'h0);

    // Preload word 0x10 = DEAD_AAEF and 0x20 = 1111_2222; writes stall but never pulse rdata_valid
    step3(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    chk("l3_w_stall_T", {31'h0, stall3}, 32'h0);
    idle3();
    chk("l3_w_stall_T1", {31'h0, stall3}, 32'h1);
    idle3();
    chk("l3_w_stall_T2", {31'h0, stall3}, 32'h1);
    step3(1'b1, 1'b1, 4'h2, 32'h10, 32'h0000_AA00);
    chk("l3_w_T3_flags", {29'h0, vld3, err3, stall3}, 32'h0);
    idle3();
    idle3();
    step3(1'b1, 1'b1, 4'hF, 32'h20, 32'h1111_2222);
    chk("l3_w2_accepted", {31'h0, stall3}, 32'h0);
    idle3();
    idle3();

    // Read 0x10 at T; en held high to 0x20 during WAIT (dropped); 0x20 re-issued at T+3
    step3(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    chk("l3_rd_T_stall", {31'h0, stall3}, 32'h0);
    step3(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    chk("l3_rd_T1", {30'h0, stall3, vld3}, 32'h2);
    step3(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    chk("l3_rd_T2", {30'h0, stall3, vld3}, 32'h2);
    step3(1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    chk("l3_rd_T3", {30'h0, stall3, vld3}, 32'h1);
    chk("l3_rd_T3_data", rdata3, 32'hDEAD_AAEF);
    idle3();
    chk("l3_rd_T4", {30'h0, stall3, vld3}, 32'h2);
    chk("l3_rd_T4_hold", rdata3, 32'hDEAD_AAEF);
    idle3();
    chk("l3_rd_T5", {30'h0, stall3, vld3}, 32'h2);
    idle3();
    chk("l3_rd_T6", {29'h0, stall3, vld3, err3}, 32'h2);
    chk("l3_rd_T6_data", rdata3, 32'h1111_2222);

    // Out-of-range read at LATENCY=3: flags land in T+3 only
    step3(1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0);
    idle3();
    idle3();
    chk("l3_oor_T2", {30'h0, vld3, err3}, 32'h0);
    idle3();
    chk("l3_oor_T3", {30'h0, vld3, err3}, 32'h3);
    chk("l3_oor_T3_data", rdata3, 32'h0);

    // Reset mid-operation: read at T, rst high for the edge ending T+1
    step3(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    idle3();
    chk("l3_rst_T1", {30'h0, stall3, vld3}, 32'h2);
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(negedge clk);
    chk("l3_rst_T2_rdata", rdata3, 32'h0);
    chk("l3_rst_T2", {29'h0, stall3, vld3, err3}, 32'h0);
    for (int k = 3; k <= 5; k++) begin
      idle3();
      chk($sformatf("l3_rst_T%0d", k), {29'h0, stall3, vld3, err3}, 32'h0);
    end

    // Data committed before reset survives
    step3(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    idle3();
    idle3();
    idle3();
    chk("l3_post_rst_vld", {31'h0, vld3}, 32'h1);
    chk("l3_post_rst_data", rdata3, 32'hDEAD_AAEF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
